cond_exec_sequencer: RTL and testbench



---
 rtl/cond_exec_sequencer.sv | 155 +++++++++++++++
 tb/tb_cond_exec_sequencer.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cond_exec_sequencer.sv
// cond_exec_sequencer: multicycle controller for the conditional-execution unit.
// Accepts one instruction descriptor at a time. Conditional instructions get a
// condition evaluation before execution; "always" instructions skip it. The
// sequencer then waits for the ALU, bounded by a watchdog, and commits or
// squashes. The flag-register write is raised only for committed instructions
// that set flags.
module cond_exec_sequencer #(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned CNT_W   = 8,
    parameter logic [2:0]  AL_CODE = 3'b111
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic             instr_setflags,
    input  logic [2:0]       instr_cond,
    input  logic             alu_done,
    input  logic             cu_out,
    output logic             cu_cond_en,
    output logic [2:0]       cu_cond,
    output logic             cu_flag_we,
    output logic             exec_commit,
    output logic             exec_squash,
    output logic             timeout_err,
    output logic             busy,
    output logic [CNT_W-1:0] commit_cnt,
    output logic [CNT_W-1:0] squash_cnt
);

    // The watchdog only has to reach TIMEOUT-1, so it needs clog2(TIMEOUT) bits.
    localparam int unsigned        WD_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0]    WD_LIMIT = WD_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EVAL  = 2'd1,
        ST_CHECK = 2'd2,
        ST_EXEC  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              setflags_q, setflags_d;
    logic [2:0]        cond_q, cond_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              timeout_err_q, timeout_err_d;
    logic [CNT_W-1:0]  commit_cnt_q, commit_cnt_d;
    logic [CNT_W-1:0]  squash_cnt_q, squash_cnt_d;

    logic              commit_s;
    logic              squash_s;

    // Next-state, latch and watchdog logic; commit/squash decided in the same cycle.
    always_comb begin
        state_d       = state_q;
        setflags_d    = setflags_q;
        cond_d        = cond_q;
        wd_d          = wd_q;
        timeout_err_d = timeout_err_q;
        commit_s      = 1'b0;
        squash_s      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    setflags_d = instr_setflags;
                    cond_d     = instr_cond;
                    wd_d       = '0;
                    state_d    = (instr_cond == AL_CODE) ? ST_EXEC : ST_EVAL;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_EVAL: begin
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (cu_out) begin
                    wd_d    = '0;
                    state_d = ST_EXEC;
                end else begin
                    squash_s = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            ST_EXEC: begin
                // alu_done on the limit cycle still counts as a commit.
                if (alu_done) begin
                    commit_s = 1'b1;
                    state_d  = ST_IDLE;
                end else if (wd_q == WD_LIMIT) begin
                    squash_s      = 1'b1;
                    timeout_err_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Saturating statistics counters.
    always_comb begin
        commit_cnt_d = commit_cnt_q;
        squash_cnt_d = squash_cnt_q;
        if (commit_s && (commit_cnt_q != CNT_MAX)) begin
            commit_cnt_d = commit_cnt_q + CNT_W'(1);
        end else begin
            commit_cnt_d = commit_cnt_q;
        end
        if (squash_s && (squash_cnt_q != CNT_MAX)) begin
            squash_cnt_d = squash_cnt_q + CNT_W'(1);
        end else begin
            squash_cnt_d = squash_cnt_q;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            setflags_q    <= 1'b0;
            cond_q        <= 3'b000;
            wd_q          <= '0;
            timeout_err_q <= 1'b0;
            commit_cnt_q  <= '0;
            squash_cnt_q  <= '0;
        end else begin
            state_q       <= state_d;
            setflags_q    <= setflags_d;
            cond_q        <= cond_d;
            wd_q          <= wd_d;
            timeout_err_q <= timeout_err_d;
            commit_cnt_q  <= commit_cnt_d;
            squash_cnt_q  <= squash_cnt_d;
        end
    end

    // Pulses are suppressed during reset so an abandoned instruction never retires.
    assign exec_commit = commit_s & ~rst;
    assign exec_squash = squash_s & ~rst;
    assign cu_flag_we  = commit_s & setflags_q & ~rst;
    assign cu_cond_en  = (state_q == ST_EVAL) & ~rst;
    assign cu_cond     = cond_q;
    assign instr_ready = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign timeout_err = timeout_err_q;
    assign commit_cnt  = commit_cnt_q;
    assign squash_cnt  = squash_cnt_q;

endmodule

// File: tb/tb_cond_exec_sequencer.sv
// Testbench for cond_exec_sequencer (TIMEOUT=4, CNT_W=2).
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
// Expected commit/squash outcomes go into a scoreboard queue when an
// instruction is issued and are popped when the DUT pulses exec_commit/exec_squash.
module tb_cond_exec_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic       instr_setflags = 1'b0;
    logic [2:0] instr_cond = 3'b000;
    logic       alu_done = 1'b0;
    logic       cu_out = 1'b0;
    logic       cu_cond_en;
    logic [2:0] cu_cond;
    logic       cu_flag_we;
    logic       exec_commit;
    logic       exec_squash;
    logic       timeout_err;
    logic       busy;
    logic [1:0] commit_cnt;
    logic [1:0] squash_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic commit;
        logic flag_we;
    } exp_t;

    exp_t sb_q[$];
    exp_t e_mon;

    logic [13:0] obs;
    assign obs = {busy, instr_ready, cu_cond_en, cu_cond, cu_flag_we, exec_commit,
                  exec_squash, timeout_err, commit_cnt, squash_cnt};
    localparam logic [13:0] OBS_RESET = {1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0,
                                         1'b0, 1'b0, 2'b00, 2'b00};

    cond_exec_sequencer #(
        .TIMEOUT (4),
        .CNT_W   (2),
        .AL_CODE (3'b111)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_setflags (instr_setflags),
        .instr_cond     (instr_cond),
        .alu_done       (alu_done),
        .cu_out         (cu_out),
        .cu_cond_en     (cu_cond_en),
        .cu_cond        (cu_cond),
        .cu_flag_we     (cu_flag_we),
        .exec_commit    (exec_commit),
        .exec_squash    (exec_squash),
        .timeout_err    (timeout_err),
        .busy           (busy),
        .commit_cnt     (commit_cnt),
        .squash_cnt     (squash_cnt)
    );

    always #5 clk = ~clk;

    // Scoreboard: every commit/squash pulse must match the oldest expected outcome.
    always @(negedge clk) begin
        if (exec_commit === 1'b1 || exec_squash === 1'b1) begin
            n_tests++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: commit=%b squash=%b flag_we=%b, none expected",
                         exec_commit, exec_squash, cu_flag_we);
            end else begin
                e_mon = sb_q.pop_front();
                if ({exec_commit, exec_squash, cu_flag_we} !== {e_mon.commit, ~e_mon.commit, e_mon.flag_we}) begin
                    n_fail++;
                    $display("FAIL sb_outcome: got commit/squash/flag_we=%b%b%b want %b%b%b",
                             exec_commit, exec_squash, cu_flag_we,
                             e_mon.commit, ~e_mon.commit, e_mon.flag_we);
                end
            end
        end
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, want finish before 200000");
        $fatal(1);
    end

    // One clock cycle: drive inputs after the rising edge, return at the falling edge.
    task automatic cyc(input logic v, input logic sf, input logic [2:0] c,
                       input logic alu, input logic cu, input logic r);
        @(posedge clk);
        #1;
        rst            = r;
        instr_valid    = v;
        instr_setflags = sf;
        instr_cond     = c;
        alu_done       = alu;
        cu_out         = cu;
        @(negedge clk);
    endtask

    task automatic do_reset();
        sb_q.delete();
        cyc(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        do_reset();
        cyc(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (obs !== OBS_RESET) begin
            n_fail++;
            $display("FAIL reset_state: got %b want %b", obs, OBS_RESET);
        end
    endtask

    task automatic test_al();
        logic en_seen;
        en_seen = 1'b0;
        do_reset();
        sb_q.push_back(exp_t'{commit: 1'b1, flag_we: 1'b1});
        cyc(1'b1, 1'b1, 3'b111, 1'b0, 1'b0, 1'b0);                 // T
        n_tests++;
        if (instr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL al_ready_T: got %b want 1", instr_ready);
        end
        en_seen = en_seen | cu_cond_en;
        cyc(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);                 // T+1
        n_tests++;
        if ({busy, instr_ready, cu_cond} !== {1'b1, 1'b0, 3'b111}) begin
            n_fail++;
            $display("FAIL al_exec_T1: got busy/ready/cond=%b%b%b want 10111", busy, instr_ready, cu_cond);
        end
        en_seen = en_seen | cu_cond_en;
        cyc(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);                 // T+2
        en_seen = en_seen | cu_cond_en;
        cyc(1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0);                 // T+3
        n_tests++;
        if ({exec_commit, cu_flag_we} !== 2'b11) begin
            n_fail++;
            $display("FAIL al_commit_T3: got commit/flag_we=%b%b want 11", exec_commit, cu_flag_we);
        end
        en_seen = en_seen | cu_cond_en;
        n_tests++;
        if (en_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL al_no_eval: cu_cond_en seen=%b want 0", en_seen);
        end
        cyc(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);                 // T+4
        n_tests++;
        if ({busy, commit_cnt, squash_cnt, sb_q.size() == 0} !== {1'b0, 2'd1, 2'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL al_after: got busy=%b commit_cnt=%0d squash_cnt=%0d sb_left=%0d want 0 1 0 0",
                     busy, commit_cnt, squash_cnt, sb_q.size());
        end
    endtask

    task automatic test_cond_pass();
        do_reset();
        sb_q.push_back(exp_t'{commit: 1'b1, flag_we: 1'b0});
        cyc(1'b1, 1'b0, 3'b100, 1'b0, 1'b0, 1'b0);                 // T
        cyc(1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0);                 // T+1 EVAL, alu_done ignored
        n_tests++;
        if ({cu_cond_en, cu_cond, exec_commit} !== {1'b1, 3'b100, 1'b0}) begin
            n_fail++;
            $display("FAIL pass_eval_T1: got en/cond/commit=%b/%b/%b want 1/100/0", cu_cond_en, cu_cond, exec_commit);
        end
        cyc(1'b0, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0);                 // T+2 CHECK
        n_tests++;
        if ({cu_cond_en, exec_squash, exec_commit} !== 3'b000) begin
            n_fail++;
            $display("FAIL pass_check_T2: got en/squash/commit=%b%b%b want 000", cu_cond_en, exec_squash, exec_commit);
        end
        cyc(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);                 // T+3 EXEC, cu_out ignored
        n_tests++;
        if ({busy, exec_commit, exec_squash} !== 3'b100) begin
            n_fail++;
            $display("FAIL pass_exec_T3: got busy/commit/squash=%b%b%b want 100", busy, exec_commit, exec_squash);
        end
        cyc(1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0);                 // T+4 commit
        n_tests++;
        if ({exec_commit, cu_flag_we} !== 2'b10) begin
            n_fail++;
            $display("FAIL pass_commit_T4: got commit/flag_we=%b%b want 10", exec_commit, cu_flag_we);
        end
        cyc(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);                 // T+5
        n_tests++;
        if ({commit_cnt, squash_cnt, sb_q.size() == 0} !== {2'd1, 2'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL pass_counts: got commit_cnt=%0d squash_cnt=%0d sb_left=%0d want 1 0 0",
                     commit_cnt, squash_cnt, sb_q.size());
        end
    endtask

    task automatic test_cond_fail();
        do_reset();
        sb_q.push_back(exp_t'{commit: 1'b0, flag_we: 1'b0});
        cyc(1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0);                 // T
        cyc(1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0);                 // T+1, cu_out ignored
        n_tests++;
        if ({cu_cond_en, cu_cond, exec_squash} !== {1'b1, 3'b000, 1'b0}) begin
            n_fail++;
            $display("FAIL fail_eval_T1: got en/cond/squash=%b/%b/%b want 1/000/0", cu_cond_en, cu_cond, exec_squash);
        end
        cyc(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);                 // T+2 CHECK fails
        n_tests++;
        if ({exec_squash, exec_commit, cu_flag_we} !== 3'b100) begin
            n_fail++;
            $display("FAIL fail_squash_T2: got squash/commit/flag_we=%b%b%b want 100", exec_squash, exec_commit, cu_flag_we);
        end
        cyc(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);                 // T+3
        n_tests++;
        if ({instr_ready, squash_cnt, commit_cnt, timeout_err} !== {1'b1, 2'd1, 2'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL fail_after_T3: got ready=%b squash_cnt=%0d commit_cnt=%0d terr=%b want 1 1 0 0",
                     instr_ready, squash_cnt, commit_cnt, timeout_err);
        end
    endtask

    task automatic test_watchdog();
        do_reset();
        sb_q.push_back(exp_t'{commit: 1'b0, flag_we: 1'b0});
        cyc(1'b1, 1'b1, 3'b111, 1'b0, 1'b0, 1'b0);                 // T
        for (int i = 1; i <= 3; i++) begin
            cyc(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);             // EXEC cycles 1..3
            n_tests++;
            if ({exec_squash, busy} !== 2'b01) begin
                n_fail++;
                $display("FAIL wd_wait_%0d: got squash/busy=%b%b want 01", i, exec_squash, busy);
            end
        end
        cyc(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);                 // 4th EXEC cycle
        n_tests++;
        if ({exec_squash, exec_commit, cu_flag_we} !== 3'b100) begin
            n_fail++;
            $display("FAIL wd_abort: got squash/commit/flag_we=%b%b%b want 100", exec_squash, exec_commit, cu_flag_we);
        end
        cyc(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if ({timeout_err, busy, squash_cnt, commit_cnt} !== {1'b1, 1'b0, 2'd1, 2'd0}) begin
            n_fail++;
            $display("FAIL wd_after: got terr=%b busy=%b squash_cnt=%0d commit_cnt=%0d want 1 0 1 0",
                     timeout_err, busy, squash_cnt, commit_cnt);
        end
        // alu_done arriving on the limit cycle commits instead.
        do_reset();
        sb_q.push_back(exp_t'{commit: 1'b1, flag_we: 1'b1});
        cyc(1'b1, 1'b1, 3'b111, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            cyc(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
        end
        cyc(1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if ({exec_commit, exec_squash} !== 2'b10) begin
            n_fail++;
            $display("FAIL wd_limit_commit: got commit/squash=%b%b want 10", exec_commit, exec_squash);
        end
        cyc(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if ({timeout_err, commit_cnt, squash_cnt, sb_q.size() == 0} !== {1'b0, 2'd1, 2'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL wd_limit_after: got terr=%b commit_cnt=%0d squash_cnt=%0d sb_left=%0d want 0 1 0 0",
                     timeout_err, commit_cnt, squash_cnt, sb_q.size());
        end
    endtask

    task automatic test_reset_mid_exec();
        do_reset();
        cyc(1'b1, 1'b1, 3'b111, 1'b0, 1'b0, 1'b0);                 // T
        cyc(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);                 // T+1
        cyc(1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1);                 // T+2 reset with alu_done
        n_tests++;
        if ({exec_commit, exec_squash, cu_flag_we} !== 3'b000) begin
            n_fail++;
            $display("FAIL rstmid_pulse: got commit/squash/flag_we=%b%b%b want 000", exec_commit, exec_squash, cu_flag_we);
        end
        cyc(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);                 // T+3
        n_tests++;
        if (obs !== OBS_RESET) begin
            n_fail++;
            $display("FAIL rstmid_state: got %b want %b", obs, OBS_RESET);
        end
    endtask

    task automatic test_back_to_back();
        logic sf;
        do_reset();
        // instr_valid held high: accept every other cycle, five commits in total.
        for (int i = 0; i < 10; i++) begin
            sf = ((i % 4) == 0);
            if ((i % 2) == 0) begin
                sb_q.push_back(exp_t'{commit: 1'b1, flag_we: sf});
            end
            cyc(1'b1, sf, 3'b111, 1'b1, 1'b0, 1'b0);
            n_tests++;
            if (instr_ready !== ((i % 2) == 0)) begin
                n_fail++;
                $display("FAIL b2b_ready_%0d: got %b want %b", i, instr_ready, ((i % 2) == 0));
            end
        end
        cyc(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if ({commit_cnt, busy, sb_q.size() == 0} !== {2'd3, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL b2b_saturate: got commit_cnt=%0d busy=%b sb_left=%0d want 3 0 0",
                     commit_cnt, busy, sb_q.size());
        end
    endtask

    task automatic test_squash_saturate();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            sb_q.push_back(exp_t'{commit: 1'b0, flag_we: 1'b0});
            cyc(1'b1, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0);
            cyc(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
            cyc(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
        end
        cyc(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if ({squash_cnt, commit_cnt, sb_q.size() == 0} !== {2'd3, 2'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL sq_saturate: got squash_cnt=%0d commit_cnt=%0d sb_left=%0d want 3 0 0",
                     squash_cnt, commit_cnt, sb_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_al();
        test_cond_pass();
        test_cond_fail();
        test_watchdog();
        test_reset_mid_exec();
        test_back_to_back();
        test_squash_saturate();
        cyc(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
